// File: rtl/adc_rx.sv
// adc_rx: WM8731 ADC receive master (b_clk/adc_lr_clk gen, 32-bit deserialiser, valid/ack; ADC_RX_SYNC_EN adds adcdat synchroniser)
module adc_rx #(
  parameter int BCLK_DIV = 2,
  parameter int FRAME_BITS = 64
) (
  input  logic        m_clk,
  input  logic        rst,
  input  logic        en,
  input  logic        adcdat,
  input  logic        sample_ack,
  output logic        b_clk,
  output logic        adc_lr_clk,
  output logic [15:0] left,
  output logic [15:0] right,
  output logic        sample_valid,
  output logic        overrun
);
  localparam int DW = BCLK_DIV > 1 ? $clog2(BCLK_DIV) : 1;
  localparam int BW = $clog2(FRAME_BITS);
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic [31:0] shift;
  logic wrap, fall, done, din;
`ifdef ADC_RX_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge m_clk) sync <= rst ? 2'b00 : {sync[0], adcdat};
  assign din = sync[1];
`else
  assign din = adcdat;
`endif
  always_comb begin
    wrap = div_cnt == DW'(BCLK_DIV - 1);
    fall = en & wrap & b_clk;
    bit_nxt = bit_cnt == BW'(FRAME_BITS - 1) ? '0 : bit_cnt + 1'b1;
    done = fall & (bit_cnt == BW'(31));
  end
  always_ff @(posedge m_clk) begin
    if (rst || !en) begin
      div_cnt <= '0;
      b_clk <= 1'b0;
      adc_lr_clk <= 1'b0;
      bit_cnt <= BW'(FRAME_BITS - 1);
      shift <= '0;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + 1'b1;
      if (wrap) b_clk <= ~b_clk;
      if (fall) begin
        bit_cnt <= bit_nxt;
        adc_lr_clk <= bit_nxt < BW'(FRAME_BITS / 2);
        if ({1'b0, bit_cnt} < (BW+1)'(32)) shift[~bit_cnt[4:0]] <= din;
      end
    end
  end
  always_ff @(posedge m_clk) begin
    if (rst) begin
      left <= '0;
      right <= '0;
      sample_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= done & sample_valid & ~sample_ack;
      if (done) begin
        left <= shift[31:16];
        right <= {shift[15:1], din};
        sample_valid <= 1'b1;
      end else if (sample_ack) begin
        sample_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_adc_rx.sv
// tb_adc_rx: directed self-checking bench for adc_rx with a WM8731-style ADC model
module tb_adc_rx;
  logic m_clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic adcdat = 1'b0;
  logic sample_ack = 1'b0;
  logic b_clk, adc_lr_clk, sample_valid, overrun;
  logic [15:0] left, right;
  int n_chk = 0;
  int n_fail = 0;
  int ovr_cnt = 0;
  logic [31:0] tx_word = '0;
  logic [31:0] cur = '0;
  int idx = 32;
  logic lr_q = 1'b0;

  adc_rx dut (
    .m_clk(m_clk), .rst(rst), .en(en), .adcdat(adcdat), .sample_ack(sample_ack),
    .b_clk(b_clk), .adc_lr_clk(adc_lr_clk), .left(left), .right(right),
    .sample_valid(sample_valid), .overrun(overrun)
  );

  always #5 m_clk = ~m_clk;

  always @(posedge b_clk) begin
    if (adc_lr_clk && !lr_q) begin
      cur = tx_word;
      idx = 0;
    end
    lr_q = adc_lr_clk;
    adcdat = idx < 32 ? cur[31-idx] : 1'b0;
    if (idx < 32) idx++;
  end

  always @(negedge m_clk) if (overrun === 1'b1) ovr_cnt++;

  task restart(input logic [31:0] w);
    @(negedge m_clk);
    rst = 1'b1;
    en = 1'b1;
    sample_ack = 1'b0;
    tx_word = w;
    repeat (3) @(negedge m_clk);
    rst = 1'b0;
  endtask

  task wait_valid(input int lim, output int k);
    k = -1;
    for (int i = 1; i <= lim; i++) begin
      @(posedge m_clk);
      @(negedge m_clk);
      if (sample_valid === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task test_reset;
    int b1, b2, l1, l2;
    logic pb, pl;
    b1 = -1; b2 = -1; l1 = -1; l2 = -1;
    @(negedge m_clk);
    rst = 1'b1;
    en = 1'b1;
    repeat (5) @(negedge m_clk);
    n_chk += 6;
    if (b_clk !== 1'b0) begin n_fail++; $display("FAIL rst_bclk got %b exp 0", b_clk); end
    if (adc_lr_clk !== 1'b0) begin n_fail++; $display("FAIL rst_lr got %b exp 0", adc_lr_clk); end
    if (left !== 16'h0) begin n_fail++; $display("FAIL rst_left got %h exp 0000", left); end
    if (right !== 16'h0) begin n_fail++; $display("FAIL rst_right got %h exp 0000", right); end
    if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", sample_valid); end
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun got %b exp 0", overrun); end
    rst = 1'b0;
    pb = 1'b0;
    pl = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge m_clk);
      if (b_clk && !pb) begin if (b1 < 0) b1 = i; else if (b2 < 0) b2 = i; end
      if (adc_lr_clk && !pl) begin if (l1 < 0) l1 = i; else if (l2 < 0) l2 = i; end
      pb = b_clk;
      pl = adc_lr_clk;
    end
    n_chk += 2;
    if (b2 - b1 !== 4 || b1 < 0) begin n_fail++; $display("FAIL bclk_period got %0d exp 4", b2 - b1); end
    if (l2 - l1 !== 256 || l1 < 0) begin n_fail++; $display("FAIL lr_period got %0d exp 256", l2 - l1); end
  endtask

  task test_single_frame;
    int k;
    int base;
    restart(32'hA5A5_3C3C);
    base = ovr_cnt;
    wait_valid(300, k);
    n_chk += 4;
    if (k + 1 !== 133) begin n_fail++; $display("FAIL single_valid_cycle got %0d exp 133", k + 1); end
    if (left !== 16'hA5A5) begin n_fail++; $display("FAIL single_left got %h exp a5a5", left); end
    if (right !== 16'h3C3C) begin n_fail++; $display("FAIL single_right got %h exp 3c3c", right); end
    @(negedge m_clk);
    if (ovr_cnt - base !== 0) begin n_fail++; $display("FAIL single_overrun got %0d exp 0", ovr_cnt - base); end
  endtask

  task test_back_to_back;
    int k1, k2, base;
    restart(32'h8000_7FFF);
    base = ovr_cnt;
    wait_valid(300, k1);
    n_chk += 3;
    if (left !== 16'h8000) begin n_fail++; $display("FAIL b2b_left1 got %h exp 8000", left); end
    if (right !== 16'h7FFF) begin n_fail++; $display("FAIL b2b_right1 got %h exp 7fff", right); end
    tx_word = 32'h0001_FFFE;
    sample_ack = 1'b1;
    @(negedge m_clk);
    sample_ack = 1'b0;
    if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_clear got %b exp 0", sample_valid); end
    wait_valid(300, k2);
    n_chk += 4;
    if (k2 < 0 || k2 + 1 !== 256) begin n_fail++; $display("FAIL b2b_spacing got %0d exp 256", k2 + 1); end
    if (left !== 16'h0001) begin n_fail++; $display("FAIL b2b_left2 got %h exp 0001", left); end
    if (right !== 16'hFFFE) begin n_fail++; $display("FAIL b2b_right2 got %h exp fffe", right); end
    sample_ack = 1'b1;
    @(negedge m_clk);
    sample_ack = 1'b0;
    @(negedge m_clk);
    if (ovr_cnt - base !== 0) begin n_fail++; $display("FAIL b2b_overrun got %0d exp 0", ovr_cnt - base); end
  endtask

  task test_overrun;
    int k, j, base;
    restart(32'h1111_2222);
    wait_valid(300, k);
    tx_word = 32'h3333_4444;
    base = ovr_cnt;
    j = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge m_clk);
      if (overrun === 1'b1) begin j = i; break; end
    end
    n_chk += 6;
    if (j !== 256) begin n_fail++; $display("FAIL ovr_pulse_cycle got %0d exp 256", j); end
    if (left !== 16'h3333) begin n_fail++; $display("FAIL ovr_left got %h exp 3333", left); end
    if (right !== 16'h4444) begin n_fail++; $display("FAIL ovr_right got %h exp 4444", right); end
    if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid got %b exp 1", sample_valid); end
    @(negedge m_clk);
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_one_cycle got %b exp 0", overrun); end
    @(negedge m_clk);
    if (ovr_cnt - base !== 1) begin n_fail++; $display("FAIL ovr_count got %0d exp 1", ovr_cnt - base); end
  endtask

  task test_collision;
    int k, base;
    restart(32'hCAFE_BABE);
    wait_valid(300, k);
    tx_word = 32'h0F0F_F0F0;
    base = ovr_cnt;
    repeat (255) @(negedge m_clk);
    n_chk += 5;
    if (left !== 16'hCAFE) begin n_fail++; $display("FAIL col_left_before got %h exp cafe", left); end
    sample_ack = 1'b1;
    @(negedge m_clk);
    sample_ack = 1'b0;
    if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL col_valid got %b exp 1", sample_valid); end
    if (left !== 16'h0F0F) begin n_fail++; $display("FAIL col_left got %h exp 0f0f", left); end
    if (right !== 16'hF0F0) begin n_fail++; $display("FAIL col_right got %h exp f0f0", right); end
    @(negedge m_clk);
    if (ovr_cnt - base !== 0) begin n_fail++; $display("FAIL col_overrun got %0d exp 0", ovr_cnt - base); end
  endtask

  task test_abort(input logic use_rst);
    int k;
    restart(32'hDEAD_BEEF);
    repeat (46) @(negedge m_clk);
    if (use_rst) rst = 1'b1;
    else en = 1'b0;
    repeat (5) @(negedge m_clk);
    n_chk += 4;
    if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL abort%0d_partial got %b exp 0", use_rst, sample_valid); end
    tx_word = 32'h1234_5678;
    rst = 1'b0;
    en = 1'b1;
    wait_valid(300, k);
    if (k + 1 !== 133) begin n_fail++; $display("FAIL abort%0d_valid_cycle got %0d exp 133", use_rst, k + 1); end
    if (left !== 16'h1234) begin n_fail++; $display("FAIL abort%0d_left got %h exp 1234", use_rst, left); end
    if (right !== 16'h5678) begin n_fail++; $display("FAIL abort%0d_right got %h exp 5678", use_rst, right); end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_overrun;
    test_collision;
    test_abort(1'b0);
    test_abort(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_rx.md
# adc_rx

Receive-side master for the WM8731 ADC serial port. Runs from `m_clk` and generates `b_clk` and `adc_lr_clk` for the codec. Deserialises `adcdat` MSB-first into one 16-bit left and one 16-bit right sample per frame, then hands the pair to the fabric with a valid/ack handshake. Sits between the codec pins and the audio processing datapath; the bench ADC functional model drives `adcdat` against it.

## Interface
- `BCLK_DIV`, default 2: `m_clk` cycles per half `b_clk` period. Legal range is ≥1, or ≥3 with the `ADC_RX_SYNC_EN` macro defined.
- `FRAME_BITS`, default 64: `b_clk` periods per `adc_lr_clk` period. Must be even and ≥32.
- `m_clk`, in, 1: system clock. All logic is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `en`, in, 1: run enable.
- `adcdat`, in, 1: serial data from the codec.
- `sample_ack`, in, 1: consumer accepts the held sample.
- `b_clk`, out, 1: generated bit clock (registered).
- `adc_lr_clk`, out, 1: generated frame clock (registered). High during the left half of the frame.
- `left`, out, 16: left sample.
- `right`, out, 16: right sample.
- `sample_valid`, out, 1: sample pair held, not yet acknowledged.
- `overrun`, out, 1: one-cycle pulse when an unacknowledged pair is overwritten.

## Operation
**Clock generation**
- `div_cnt` counts 0..BCLK_DIV-1. On wrap, `b_clk` toggles.
- A **rise event** is a wrap with `b_clk`=0. A **fall event** is a wrap with `b_clk`=1.
- `bit_cnt` counts 0..FRAME_BITS-1 and advances only on a fall event, wrapping to 0.
- On every fall event, `adc_lr_clk` is updated to (new `bit_cnt` < FRAME_BITS/2). It therefore rises on the fall event where `bit_cnt` wraps to 0.

**Capture**
- The codec drives each bit on a `b_clk` rising edge. The block samples it on the next fall event.
- At the fall event where `bit_cnt` goes k→k+1, for k in 0..31, bit 31-k of `shift` is loaded from `adcdat`.
- Bits driven while `bit_cnt` ≥ 32 are ignored.
- At the fall event where k=31 (the word is complete):
  - `left` ← `shift[31:16]` and `right` ← `shift[15:0]`, including the bit captured in that same cycle.
  - `sample_valid` ← 1.
  - If `sample_valid` was already 1 and `sample_ack` is not high in that cycle, `overrun` pulses for 1 cycle and the new data replaces the old.

**Handshake**
- `sample_valid` clears on the cycle after any cycle with `sample_ack`=1 and `sample_valid`=1.
- `sample_ack` while `sample_valid`=0 is ignored.
- If an ack and a new word completion happen in the same cycle, the new word wins: `sample_valid` stays 1 and `overrun` stays 0.

**Enable and reset**
- `en`=0 holds the generator in its reset state: `div_cnt`=0, `b_clk`=0, `adc_lr_clk`=0, `bit_cnt`=FRAME_BITS-1, `shift`=0.
- `en`=0 does not affect `left`, `right` or `sample_valid`, and the handshake still operates.
- Deasserting `en` mid-frame discards the partial word. Reasserting it starts a fresh frame.
- `rst` puts every register into the following state, regardless of `en`:
  - `b_clk`=0, `adc_lr_clk`=0, `div_cnt`=0
  - `bit_cnt`=FRAME_BITS-1, `shift`=0
  - `left`=0, `right`=0, `sample_valid`=0, `overrun`=0
- `rst` mid-frame discards the partial word and drops any held sample.

## Timing
- Periods: `b_clk` = 2·BCLK_DIV `m_clk` cycles; `adc_lr_clk` = 2·BCLK_DIV·FRAME_BITS cycles. With defaults: 4 and 256 cycles.
- Counting cycles from the first `m_clk` edge with `rst`=0 and `en`=1:
  - First rise event is at cycle BCLK_DIV.
  - First fall event (`adc_lr_clk`→1) is at cycle 2·BCLK_DIV.
  - Word completes on fall event number 33, at cycle 66·BCLK_DIV.
- `sample_valid` is visible one cycle after the completing fall event. With defaults: word completes at cycle 132, `sample_valid` is high from cycle 133.
- Subsequent words complete every 2·BCLK_DIV·FRAME_BITS cycles.
- `adc_lr_clk` falls at the same fall event that completes the word. With defaults, that is valid because FRAME_BITS/2 = 32.

## Configuration
- `ADC_RX_SYNC_EN` defined:
  - `adcdat` passes through a 2-flop `m_clk` synchroniser, reset to 0, and capture uses the synchronised value.
  - Capture timing at fall events is unchanged. BCLK_DIV must be ≥3 so the synchronised bit is stable at the fall event.
- `ADC_RX_SYNC_EN` undefined: `adcdat` is sampled directly at the fall event.

## Test plan
1. **Reset values:** assert `rst` for 5 cycles with `en`=1 → all outputs 0 while `rst` is high. Measured `b_clk` period = 4 `m_clk` cycles and `adc_lr_clk` period = 256 `m_clk` cycles after release.
2. **Single frame:** model writes 32'hA5A5_3C3C after `adc_lr_clk` rises → `sample_valid` rises at cycle 133 with `left`=16'hA5A5 and `right`=16'h3C3C. `overrun`=0.
3. **Back-to-back frames:** frames 32'h8000_7FFF then 32'h0001_FFFE, each acknowledged one cycle after valid → two pairs delivered 256 cycles apart, `overrun` never pulses.
4. **Overrun:** two frames, never acknowledged → `overrun` pulses once at completion of the second frame, and the outputs show the second frame's data.
5. **Ack collision:** ack held high on exactly the cycle the next word completes → `sample_valid` stays 1, new data is presented, `overrun`=0.
6. **Abort mid-frame:** drop `en` (and, in a separate run, pulse `rst`) after 10 bits of a frame → no sample produced from the partial word, and the next full frame 32'h1234_5678 is delivered correctly.
